// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg -- shared types and constants for the FIFO write arbiter.
//   state_e   : arbiter state (ST_IDLE / ST_OWN)
//   MAX_REQ   : largest supported requester count
//   PTR_W     : width of a requester index / round-robin pointer
//   WDT_W     : watchdog counter width (covers wdt_cycles up to 255)
//   next_ptr(): round-robin successor of an owner index
package fifo_wr_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_e;

   localparam int MAX_REQ = 4;
   localparam int PTR_W   = $clog2(MAX_REQ);
   localparam int WDT_W   = 8;

   // (g + 1) mod n, without a divider
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] g, input int n);
      return (int'(g) == n - 1) ? '0 : g + PTR_W'(1);
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick -- combinational round-robin picker.
//   req_i : request vector
//   ptr_i : index where the search starts (highest priority)
//   gnt_o : one-hot winner, all-zero when no request is set
module rr_pick
   import fifo_wr_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o
);

   logic found;

   // Two passes avoid a modulo index: first ptr..N-1, then wrap to 0..ptr-1.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (i >= int'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb -- packet-atomic round-robin arbiter writing into one FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/data/last, req_ready : per-requester beat handshake
//   fifo_wen, fifo_din, fifo_full_n: FIFO write port
//   grant           : one-hot current owner, zero while idle
//   wdt_abort       : one-cycle pulse when the watchdog releases an owner
// Optional feature: define FIFO_WR_ARB_WDT_EN to build the idle watchdog;
// otherwise wdt_abort is tied low and no counter exists.
module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter int req_n      = 3,
   parameter int data_width = 8,
   parameter int wdt_cycles = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [req_n-1:0]            req_valid,
   input  logic [req_n*data_width-1:0] req_data,
   input  logic [req_n-1:0]            req_last,
   output logic [req_n-1:0]            req_ready,
   output logic                        fifo_wen,
   output logic [data_width-1:0]       fifo_din,
   input  logic                        fifo_full_n,
   output logic [req_n-1:0]            grant,
   output logic                        wdt_abort
);

   if (req_n < 2 || req_n > MAX_REQ) begin : g_bad_req_n
      $error("fifo_wr_arb: req_n out of range");
   end
   if (wdt_cycles < 2 || wdt_cycles > 255) begin : g_bad_wdt
      $error("fifo_wr_arb: wdt_cycles out of range");
   end

   state_e             state_q, state_d;
   logic [req_n-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [req_n-1:0]   pick;
   logic [PTR_W-1:0]   own_idx;
   logic               own_vld, own_last, accept, wdt_fire;

   rr_pick #(.N(req_n)) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   // Owner's handshake signals, selected by the registered one-hot grant.
   always_comb begin
      own_idx  = '0;
      own_vld  = 1'b0;
      own_last = 1'b0;
      for (int i = 0; i < req_n; i++) begin
         if (grant_q[i]) begin
            own_idx  = PTR_W'(i);
            own_vld  = req_valid[i];
            own_last = req_last[i];
         end
      end
   end

   assign accept = (state_q == ST_OWN) && own_vld && fifo_full_n;

`ifdef FIFO_WR_ARB_WDT_EN
   localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(wdt_cycles - 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic             wdt_abort_q;

   // Counts owner cycles without valid; a valid beat (even one stalled by a
   // full FIFO) proves the owner is alive and clears the count.
   always_comb begin
      wdt_cnt_d = wdt_cnt_q;
      wdt_fire  = 1'b0;
      if (state_q != ST_OWN || own_vld) begin
         wdt_cnt_d = '0;
      end else if (wdt_cnt_q == WDT_LAST) begin
         wdt_fire  = 1'b1;
         wdt_cnt_d = '0;
      end else begin
         wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt_q   <= '0;
         wdt_abort_q <= 1'b0;
      end else begin
         wdt_cnt_q   <= wdt_cnt_d;
         wdt_abort_q <= wdt_fire;
      end
   end

   assign wdt_abort = wdt_abort_q;
`else
   assign wdt_fire  = 1'b0;
   assign wdt_abort = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               state_d = ST_OWN;
               grant_d = pick;
            end
         end
         ST_OWN: begin
            if ((accept && own_last) || wdt_fire) begin
               state_d = ST_IDLE;
               grant_d = '0;
               ptr_d   = next_ptr(own_idx, req_n);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: only the owner sees ready; the FIFO path is purely combinational.
   always_comb begin
      req_ready = '0;
      fifo_wen  = 1'b0;
      fifo_din  = '0;
      if (state_q == ST_OWN) begin
         req_ready = grant_q & {req_n{fifo_full_n}};
         fifo_wen  = own_vld && fifo_full_n;
         for (int i = 0; i < req_n; i++) begin
            if (grant_q[i]) fifo_din = req_data[i*data_width +: data_width];
         end
      end
   end

   assign grant = grant_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb -- directed and random checks of fifo_wr_arb against a
// transaction-level reference (owner index, round-robin pointer, idle count).
// Define FIFO_WR_ARB_WDT_EN for both bench and RTL to cover the watchdog.
module tb_fifo_wr_arb;

   localparam int N   = 3;
   localparam int DW  = 8;
   localparam int WDT = 16;
`ifdef FIFO_WR_ARB_WDT_EN
   localparam bit WDT_ON = 1'b1;
`else
   localparam bit WDT_ON = 1'b0;
`endif

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid, req_last, req_ready, grant;
   logic [N*DW-1:0] req_data;
   logic            fifo_wen, fifo_full_n, wdt_abort;
   logic [DW-1:0]   fifo_din;

   fifo_wr_arb #(.req_n(N), .data_width(DW), .wdt_cycles(WDT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .fifo_wen    (fifo_wen),
      .fifo_din    (fifo_din),
      .fifo_full_n (fifo_full_n),
      .grant       (grant),
      .wdt_abort   (wdt_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   beat_t        srcq [N][$];
   logic [N-1:0] bubble;

   int errors = 0;
   int checks = 0;

   // reference model
   int m_owner, m_ptr, m_cnt;
   bit m_abort, m_known;

   int           cyc;
   logic [N-1:0] prev_g;
   logic [DW-1:0] wlog[$];
   int           wcyc[$];
   int           glog[$];
   int           gcyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
      for (int b = 0; b < len; b++)
         srcq[r].push_back(beat_t'{d: base + DW'(b), l: (b == len - 1)});
   endtask

   task automatic clear_logs();
      wlog.delete(); wcyc.delete(); glog.delete(); gcyc.delete();
   endtask

   // One clock: drive at negedge, check combinational outputs, then advance
   // the model and the requester queues at the posedge.
   task automatic cycle(input logic r, input logic fn);
      logic [N-1:0] acc;
      logic [N-1:0] eg, er;
      logic         ew;
      @(negedge clk);
      rst         = r;
      fifo_full_n = fn;
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0 && !bubble[i]) begin
            req_valid[i]           = 1'b1;
            req_last[i]            = srcq[i][0].l;
            req_data[i*DW +: DW]   = srcq[i][0].d;
         end else begin
            req_valid[i]           = 1'b0;
            req_last[i]            = 1'($urandom);
            req_data[i*DW +: DW]   = DW'($urandom);
         end
      end
      #1;
      if (m_known) begin
         eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
         er = (m_owner < 0 || !fn) ? '0 : N'(1 << m_owner);
         ew = (m_owner >= 0) && req_valid[m_owner] && fn;
         chk("grant", 32'(grant), 32'(eg));
         chk("req_ready", 32'(req_ready), 32'(er));
         chk("fifo_wen", 32'(fifo_wen), 32'(ew));
         if (ew) chk("fifo_din", 32'(fifo_din), 32'(req_data[m_owner*DW +: DW]));
         chk("wdt_abort", 32'(wdt_abort), 32'(m_abort));
      end
      if (fifo_wen) begin
         wlog.push_back(fifo_din);
         wcyc.push_back(cyc);
      end
      if (grant != '0 && grant != prev_g) begin
         for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
         gcyc.push_back(cyc);
      end
      prev_g = grant;
      acc    = req_valid & req_ready;
      @(posedge clk);
      for (int i = 0; i < N; i++) if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (r) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0; m_abort = 1'b0; m_known = 1'b1;
      end else if (m_known) begin
         m_abort = 1'b0;
         if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
               if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            m_cnt = 0;
         end else if (req_valid[m_owner] && fn && req_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else if (WDT_ON && !req_valid[m_owner]) begin
            m_cnt++;
            if (m_cnt == WDT) begin
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
               m_abort = 1'b1;
               m_cnt   = 0;
            end
         end else begin
            m_cnt = 0;
         end
      end
      cyc++;
   endtask

   initial begin : stim
      logic [DW-1:0] e35 [6];
      logic [DW-1:0] e36 [6];
      int            c0, nb, at;
      e35 = '{8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
      e36 = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};
      rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full_n = 1'b1;
      bubble = '0; m_known = 1'b0; m_owner = -1; m_ptr = 0; m_cnt = 0; m_abort = 1'b0;
      cyc = 0; prev_g = '0;

      // reset for two cycles, then quiet
      cycle(1, 1); cycle(1, 1);
      cycle(0, 1); cycle(0, 1);

      // req0 and req2 together, 3 beats each
      clear_logs();
      c0 = cyc;
      push_pkt(0, 3, 8'h10);
      push_pkt(2, 3, 8'h30);
      repeat (10) cycle(0, 1);
      chk("r35_nwrites", 32'(wlog.size()), 32'd6);
      for (int k = 0; k < 6 && k < wlog.size(); k++) chk("r35_data", 32'(wlog[k]), 32'(e35[k]));
      chk("r35_first_owner", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);
      chk("r35_second_owner", 32'(glog.size() > 1 ? glog[1] : -1), 32'd2);
      chk("r35_owner2_start", 32'(gcyc.size() > 1 ? gcyc[1] - c0 : -1), 32'd5);
      chk("r35_total_cycles", 32'(wcyc.size() > 5 ? wcyc[5] - c0 + 1 : -1), 32'd8);

      // req1 owns 4 beats with a 5-cycle stall; req0 waits throughout
      clear_logs();
      push_pkt(1, 4, 8'h50);
      cycle(0, 1);
      push_pkt(0, 2, 8'h60);
      cycle(0, 1);
      nb = wlog.size();
      repeat (5) cycle(0, 0);
      chk("r36_stall_writes", 32'(wlog.size() - nb), 32'd0);
      repeat (8) cycle(0, 1);
      chk("r36_nwrites", 32'(wlog.size()), 32'd6);
      for (int k = 0; k < 6 && k < wlog.size(); k++) chk("r36_order", 32'(wlog[k]), 32'(e36[k]));

      // reset in the middle of req0's packet, then req1 alone
      push_pkt(0, 4, 8'h70);
      cycle(0, 1);
      cycle(0, 1);
      cycle(1, 1);
      srcq[0].delete();
      #1 chk("r39_grant_cleared", 32'(grant), 32'd0);
      push_pkt(1, 1, 8'h80);
      cycle(0, 1);
      #1 chk("r39_req1_grant", 32'(grant), 32'b010);
      cycle(0, 1);

      // everyone streaming single-beat packets
      cycle(1, 1);
      clear_logs();
      for (int i = 0; i < N; i++) begin
         push_pkt(i, 1, DW'(8'hA0 + i));
         push_pkt(i, 1, DW'(8'hB0 + i));
      end
      repeat (14) cycle(0, 1);
      chk("r37_ngrants", 32'(glog.size()), 32'd6);
      for (int k = 0; k < 6 && k < glog.size(); k++) chk("r37_seq", 32'(glog[k]), 32'(k % 3));
      for (int k = 1; k < 6 && k < gcyc.size(); k++) chk("r37_gap", 32'(gcyc[k] - gcyc[k-1]), 32'd2);

      // req1 sends one beat without last, then goes silent
      cycle(1, 1);
      srcq[1].push_back(beat_t'{d: 8'hC0, l: 1'b0});
      cycle(0, 1);
      cycle(0, 1);
`ifdef FIFO_WR_ARB_WDT_EN
      at = -1;
      for (int n = 1; n <= 40; n++) begin
         cycle(0, 1);
         #1;
         if (at < 0 && wdt_abort) begin
            at = n;
            chk("r38_grant_cleared", 32'(grant), 32'd0);
         end
      end
      chk("r38_abort_cycle", 32'(at), 32'(WDT));
      for (int i = 0; i < N; i++) push_pkt(i, 1, DW'(8'hD0 + i));
      cycle(0, 1);
      #1 chk("r38_ptr_is_2", 32'(grant), 32'b100);
      repeat (8) cycle(0, 1);
`else
      at = 0;
      repeat (2 * WDT) cycle(0, 1);
      #1 chk("nowdt_still_owned", 32'(grant), 32'b010);
      chk("nowdt_abort_low", 32'(wdt_abort), 32'(at));
`endif
      cycle(1, 1);

      // random traffic, back-pressure, bubbles and occasional resets
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++)
            if (srcq[i].size() == 0 && $urandom_range(3) == 0)
               push_pkt(i, $urandom_range(1, 4), DW'($urandom));
         for (int i = 0; i < N; i++) bubble[i] = ($urandom_range(3) == 0);
         cycle(($urandom_range(249) == 0), ($urandom_range(3) != 0));
      end
      bubble = '0;
      repeat (4) cycle(0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
